// File: rtl/tt_mux_slot_ctrl.sv
// Project-slot multiplexer: routes one pad-side flat bus to one of NUM_PROJ project slots,
// sequencing every project switch through guard (all ena low) and forced-reset phases.
module tt_mux_slot_ctrl #(
   parameter int NUM_PROJ     = 4,
   parameter int IW           = 18,
   parameter int OW           = 24,
   parameter int GUARD_CYCLES = 2,
   parameter int RST_CYCLES   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sel_valid,
   input  logic [$clog2(NUM_PROJ)-1:0]   sel_addr,
   output logic                          sel_ready,
   output logic                          sel_err,
   output logic                          active,
   output logic [$clog2(NUM_PROJ)-1:0]   active_sel,
   input  logic [IW-1:0]                 pad_iw,
   output logic [OW-1:0]                 pad_ow,
   output logic [NUM_PROJ*IW-1:0]        proj_iw,
   input  logic [NUM_PROJ*OW-1:0]        proj_ow,
   output logic [NUM_PROJ-1:0]           proj_ena
);

   localparam int AW   = $clog2(NUM_PROJ);
   localparam int CMAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [AW:0]   NP_LIM     = (AW+1)'(NUM_PROJ);
   localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GUARD,
      S_RESET,
      S_RUN
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [AW-1:0]       sel_q, sel_d;
   logic                err_q;
   logic [OW-1:0]       pad_ow_q;

   logic                accept;
   logic                addr_ok;
   logic                proj_live;
   logic [NUM_PROJ-1:0] sel_onehot;
   logic [OW-1:0]       ow_sel;
   logic [IW-1:0]       iw_sel;

   assign sel_ready  = (state_q == S_IDLE) || (state_q == S_RUN);
   assign accept     = sel_valid && sel_ready;
   // Only reachable when NUM_PROJ is not a power of two.
   assign addr_ok    = {1'b0, sel_addr} < NP_LIM;

   assign sel_err    = err_q;
   assign active     = (state_q == S_RUN);
   assign active_sel = sel_q;
   assign pad_ow     = pad_ow_q;
   assign proj_live  = (state_q == S_RESET) || (state_q == S_RUN);

   // NOTE: every signal written in an always_comb gets a default first, so no path
   // through the case/if leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (accept && addr_ok) begin
               state_d = S_GUARD;
               cnt_d   = GUARD_LOAD;
               sel_d   = sel_addr;
            end
         end
         S_GUARD: begin
            if (cnt_q == '0) begin
               state_d = S_RESET;
               cnt_d   = RST_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_RESET: begin
            if (cnt_q == '0) state_d = S_RUN;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sel_onehot = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (sel_q == AW'(k)) sel_onehot[k] = 1'b1;
      end
   end

   always_comb begin
      ow_sel = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (sel_onehot[k]) ow_sel = ow_sel | proj_ow[k*OW +: OW];
      end
   end

   // During RESET the project sees its clock but a held-low rst_n.
   always_comb begin
      iw_sel = pad_iw;
      if (state_q == S_RESET) iw_sel[1] = 1'b0;
   end

   always_comb begin
      proj_ena = proj_live ? sel_onehot : '0;
      proj_iw  = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (proj_ena[k]) proj_iw[k*IW +: IW] = iw_sel;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of its sources, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         err_q    <= 1'b0;
         pad_ow_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         err_q    <= accept && !addr_ok;
         // Zero unless the next cycle is RUN, so a switch never leaks old project data.
         pad_ow_q <= (state_d == S_RUN) ? ow_sel : '0;
      end
   end

endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// Randomised scoreboard bench for tt_mux_slot_ctrl, checked against a phase-age reference model.
module tb_tt_mux_slot_ctrl;

   // Five slots give a 3-bit address, so out-of-range requests (5..7) are representable.
   localparam int NP = 5;
   localparam int AW = $clog2(NP);
   localparam int IW = 18;
   localparam int OW = 24;
   localparam int G  = 2;
   localparam int R  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sel_valid = 1'b0;
   logic [AW-1:0]     sel_addr = '0;
   logic [IW-1:0]     pad_iw = '0;
   logic [NP*OW-1:0]  proj_ow = '0;
   logic              sel_ready, sel_err, active;
   logic [AW-1:0]     active_sel;
   logic [OW-1:0]     pad_ow;
   logic [NP*IW-1:0]  proj_iw;
   logic [NP-1:0]     proj_ena;

   tt_mux_slot_ctrl #(
      .NUM_PROJ(NP), .IW(IW), .OW(OW), .GUARD_CYCLES(G), .RST_CYCLES(R)
   ) u_dut (
      .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_addr(sel_addr),
      .sel_ready(sel_ready), .sel_err(sel_err), .active(active), .active_sel(active_sel),
      .pad_iw(pad_iw), .pad_ow(pad_ow), .proj_iw(proj_iw), .proj_ow(proj_ow),
      .proj_ena(proj_ena)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             ready;
      logic             err;
      logic             active;
      logic [AW-1:0]    asel;
      logic [NP-1:0]    ena;
      logic [OW-1:0]    pow;
      logic [NP*IW-1:0] piw;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: m_age counts cycles since the last accepted select
   // (1..G guard, G+1..G+R forced reset, beyond that the project runs).
   bit            m_on  = 1'b0;
   int            m_age = 0;
   int            m_sel = 0;
   bit            m_err = 1'b0;
   logic [OW-1:0] m_pad = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return !m_on || (m_age > G + R);
   endfunction

   // Advance the model across one clock edge using the inputs present before it.
   task automatic model_edge();
      bit acc;
      if (rst) begin
         m_on = 1'b0; m_age = 0; m_sel = 0; m_err = 1'b0; m_pad = '0;
      end else begin
         acc   = sel_valid && m_ready();
         m_err = acc && (int'(sel_addr) >= NP);
         if (acc && int'(sel_addr) < NP) begin
            m_on = 1'b1; m_age = 1; m_sel = int'(sel_addr);
         end else if (m_on && m_age <= G + R) begin
            m_age++;
         end
         m_pad = (m_on && m_age > G + R) ? proj_ow[m_sel*OW +: OW] : '0;
      end
   endtask

   function automatic exp_t expect_now();
      exp_t          x;
      bit            run, rphase;
      logic [IW-1:0] slot;
      run    = m_on && (m_age > G + R);
      rphase = m_on && (m_age > G) && (m_age <= G + R);
      x.ready  = !m_on || run;
      x.err    = m_err;
      x.active = run;
      x.asel   = AW'(m_sel);
      x.pow    = m_pad;
      x.ena    = '0;
      x.piw    = '0;
      if (run || rphase) begin
         slot = pad_iw;
         if (rphase) slot[1] = 1'b0;
         x.ena[m_sel]           = 1'b1;
         x.piw[m_sel*IW +: IW]  = slot;
      end
      return x;
   endfunction

   function automatic logic [NP*OW-1:0] rand_ow();
      logic [NP*OW-1:0] v;
      for (int k = 0; k < NP; k++) v[k*OW +: OW] = OW'($urandom);
      return v;
   endfunction

   task automatic tick(input bit r, input bit v, input logic [AW-1:0] a,
                       input logic [IW-1:0] piw, input logic [NP*OW-1:0] pow);
      @(posedge clk);
      #1;
      model_edge();
      rst       = r;
      sel_valid = v;
      sel_addr  = a;
      pad_iw    = piw;
      proj_ow   = pow;
      q.push_back(expect_now());
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, '0, IW'($urandom), rand_ow());
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         e = q.pop_front();
         check("sel_ready",  sel_ready,  e.ready);
         check("sel_err",    sel_err,    e.err);
         check("active",     active,     e.active);
         check("active_sel", active_sel, e.asel);
         check("proj_ena",   proj_ena,   e.ena);
         check("pad_ow",     pad_ow,     e.pow);
         check("proj_iw",    proj_iw,    e.piw);
         check("ena_onehot", ($countones(proj_ena) <= 1), 1'b1);
      end
   end

   logic [NP*OW-1:0] fix_ow;

   initial begin
      tick(1'b1, 1'b0, '0, '0, '0);
      tick(1'b1, 1'b0, '0, '0, '0);
      idle(2);

      // Select slot 2 and walk through guard, reset and into run.
      tick(1'b0, 1'b1, AW'(2), IW'($urandom), rand_ow());
      idle(9);

      // Fixed pattern on slot 2 and an all-ones pad bus.
      for (int i = 0; i < 4; i++) begin
         fix_ow = rand_ow();
         fix_ow[2*OW +: OW] = 24'hA5C3F0;
         tick(1'b0, 1'b0, '0, 18'h3FFFF, fix_ow);
      end
      idle(2);

      // Out-of-range requests while running, then one from IDLE further below.
      tick(1'b0, 1'b1, AW'(5), IW'($urandom), rand_ow());
      idle(2);
      tick(1'b0, 1'b1, AW'(7), IW'($urandom), rand_ow());
      idle(2);

      // Switch mid-run from slot 2 to slot 0.
      tick(1'b0, 1'b1, AW'(0), IW'($urandom), rand_ow());
      idle(9);

      // Request slot 3, then keep sel_valid asserted through guard/reset.
      tick(1'b0, 1'b1, AW'(3), IW'($urandom), rand_ow());
      do tick(1'b0, 1'b1, AW'(4), IW'($urandom), rand_ow()); while (!m_ready());
      idle(10);

      // Reset asserted during the forced-reset phase.
      tick(1'b0, 1'b1, AW'(1), IW'($urandom), rand_ow());
      idle(G + 1);
      tick(1'b1, 1'b0, '0, IW'($urandom), rand_ow());
      idle(3);

      tick(1'b0, 1'b1, AW'(6), IW'($urandom), rand_ow());
      idle(3);

      // Select the highest legal slot, then re-select it while running.
      tick(1'b0, 1'b1, AW'(NP-1), IW'($urandom), rand_ow());
      idle(8);
      tick(1'b0, 1'b1, AW'(NP-1), IW'($urandom), rand_ow());
      idle(8);

      repeat (1500) begin
         tick(($urandom % 60) == 0, ($urandom % 8) == 0, AW'($urandom % 8),
              IW'($urandom), rand_ow());
      end
      idle(1);

      @(negedge clk);
      #1;
      check("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
